// File: rtl/photon_gate_counter.sv
// Purpose: counts synchronized photon rising edges between trigger edges, queues each window count for the host.
// Latency: photon pin to counter 3 CLK; trigger edge to FIFO entry 1 CLK; Avalon readdata 1 CLK after read.
// Backpressure: none toward the sources; a full FIFO drops the new count and sets the sticky ovf flag.
module photon_gate_counter #(
  parameter int CNT_W   = 32,
  parameter int FIFO_AW = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        trig,
  input  logic        photon,
  input  logic        address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [FIFO_AW:0]   PTR_ONE = (FIFO_AW + 1)'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OPEN = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Input conditioning registers
  logic ph_s1_q, ph_s2_q, ph_s3_q;
  logic trig_prev_q;
  logic pe, te;

  // Window counter
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  // FIFO storage and pointers (one extra wrap bit distinguishes full from empty)
  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [FIFO_AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_AW:0] level, level_d;
  logic             empty, full;

  // Status / host-facing registers
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;

  // Control decode
  logic push_req, push, pop, drop, flush, clr_ovf, armed;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:2];

  // Photon 2-flop synchronizer plus edge-history flop; trigger edge history.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ph_s1_q     <= 1'b0;
      ph_s2_q     <= 1'b0;
      ph_s3_q     <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      ph_s1_q     <= photon;
      ph_s2_q     <= ph_s1_q;
      ph_s3_q     <= ph_s2_q;
      trig_prev_q <= trig;
    end
  end

  // Trigger is already synchronous, so only its first high cycle matters.
  assign pe = ph_s2_q & ~ph_s3_q;
  assign te = trig & ~trig_prev_q;

  assign flush   = write & address & writedata[1];
  assign clr_ovf = write & address & writedata[0];
  assign armed   = (state_q == S_OPEN);

  // Count including a photon edge in this cycle, held at all-ones once reached.
  assign cnt_inc = (pe && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_ONE) : cnt_q;

  // Window FSM: next state, counter next value and close-of-window request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    push_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Photons before the first trigger belong to no window.
        cnt_d = '0;
        if (te && !flush) begin
          state_d = S_OPEN;
        end
      end
      S_OPEN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (te) begin
          // A photon coincident with the trigger is part of the closing window.
          push_req = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FIFO occupancy and push/pop arbitration.
  assign level = wr_q - rd_q;
  assign empty = (level == '0);
  assign full  = level[FIFO_AW];

  always_comb begin
    pop     = read & ~address & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still fits.
    push    = push_req & (~full | pop);
    drop    = push_req & full & ~pop;
    wr_d    = push ? (wr_q + PTR_ONE) : wr_q;
    rd_d    = rd_q;
    if (flush) begin
      rd_d = wr_q;
    end else if (pop) begin
      rd_d = rd_q + PTR_ONE;
    end
    level_d = wr_d - rd_d;
    irq_d   = (level_d != '0);
    ovf_d   = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Avalon read mux; readdata holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (read) begin
      if (!address) begin
        rdata_d = empty ? 32'd0 : 32'(mem_q[rd_q[FIFO_AW-1:0]]);
      end else begin
        rdata_d = {ovf_q, armed, 14'd0, 16'(level)};
      end
    end
  end

  // FIFO storage: contents need no reset, validity comes from the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_q[FIFO_AW-1:0]] <= cnt_inc;
    end
  end

  // State, counter, pointers and host-visible registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_photon_gate_counter.sv
// Directed bench for photon_gate_counter: main instance (32-bit counter, 16-deep FIFO)
// plus a narrow-counter instance that reaches saturation in a few photons.
module tb_photon_gate_counter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        trig, photon, address, read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  logic        trig2, photon2, address2, read2, write2;
  logic [31:0] writedata2;
  logic [31:0] readdata2;
  logic        irq2;

  int n_checks = 0;
  int n_fail   = 0;

  photon_gate_counter #(.CNT_W(32), .FIFO_AW(4)) dut (
    .CLK(CLK), .RST(RST), .trig(trig), .photon(photon),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  photon_gate_counter #(.CNT_W(4), .FIFO_AW(2)) dut_sat (
    .CLK(CLK), .RST(RST), .trig(trig2), .photon(photon2),
    .address(address2), .read(read2), .write(write2), .writedata(writedata2),
    .readdata(readdata2), .irq(irq2)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    tick();
    trig = 1'b0;
    tick();
  endtask

  task automatic photons(input int n);
    for (int i = 0; i < n; i++) begin
      photon = 1'b1;
      idle(3);
      photon = 1'b0;
      idle(3);
    end
  endtask

  task automatic rd(input logic a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    address = 1'b0;
    d       = readdata;
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    address   = 1'b1;
    write     = 1'b1;
    writedata = v;
    tick();
    write     = 1'b0;
    writedata = 32'd0;
    address   = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    rd(1'b1, d);
    check(tag, d, exp);
  endtask

  task automatic chk_data(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    rd(1'b0, d);
    check(tag, d, exp);
  endtask

  task automatic pulse_trig2();
    trig2 = 1'b1;
    tick();
    tick();
    trig2 = 1'b0;
    tick();
  endtask

  task automatic photons2(input int n);
    for (int i = 0; i < n; i++) begin
      photon2 = 1'b1;
      idle(3);
      photon2 = 1'b0;
      idle(3);
    end
  endtask

  task automatic rd2(input logic a, output logic [31:0] d);
    address2 = a;
    read2    = 1'b1;
    tick();
    read2    = 1'b0;
    address2 = 1'b0;
    d        = readdata2;
  endtask

  initial begin
    logic [31:0] d;
    RST = 1'b1;
    trig = 1'b0; photon = 1'b0; address = 1'b0; read = 1'b0; write = 1'b0; writedata = 32'd0;
    trig2 = 1'b0; photon2 = 1'b0; address2 = 1'b0; read2 = 1'b0; write2 = 1'b0; writedata2 = 32'd0;
    idle(3);

    // Reset state
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    RST = 1'b0;
    tick();
    chk_status("rst_status", 32'h0000_0000);

    // 1: one window of 5 photons
    pulse_trig();
    photons(5);
    idle(10);
    pulse_trig();
    check("t1_irq_set", {31'd0, irq}, 32'd1);
    chk_status("t1_status", 32'h4000_0001);
    chk_data("t1_data", 32'd5);
    check("t1_irq_clr", {31'd0, irq}, 32'd0);

    // 2: photons before arming are discarded
    wr_ctrl(32'h2);
    chk_status("t2_flushed", 32'h0000_0000);
    photons(3);
    pulse_trig();
    chk_status("t2_armed_empty", 32'h4000_0000);
    photons(2);
    pulse_trig();
    chk_data("t2_data", 32'd2);

    // 3: photon edge coincident with trigger edge closes with the old window
    photons(2);
    photon = 1'b1;
    tick();
    tick();
    trig = 1'b1;
    tick();
    tick();
    trig = 1'b0;
    photon = 1'b0;
    idle(3);
    photons(1);
    pulse_trig();
    chk_data("t3_closing", 32'd3);
    chk_data("t3_next", 32'd1);

    // 4: 17 windows into a 16-deep FIFO
    for (int i = 1; i <= 17; i++) begin
      photons(i);
      pulse_trig();
    end
    check("t4_irq", {31'd0, irq}, 32'd1);
    chk_status("t4_full_ovf", 32'hC000_0010);
    chk_data("t4_first", 32'd1);
    chk_status("t4_after_pop", 32'hC000_000F);
    wr_ctrl(32'h1);
    chk_status("t4_ovf_clr", 32'h4000_000F);
    photons(3);
    pulse_trig();
    chk_status("t4_full_again", 32'h4000_0010);
    // push and pop of a full FIFO in the same cycle
    photons(7);
    trig    = 1'b1;
    address = 1'b0;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    d       = readdata;
    tick();
    trig    = 1'b0;
    tick();
    check("t4_pop_push_data", d, 32'd2);
    chk_status("t4_pop_push_lvl", 32'h4000_0010);
    chk_data("t4_third", 32'd3);
    idle(3);
    check("t4_hold", readdata, 32'd3);
    wr_ctrl(32'h2);

    // 5: empty read and mid-window flush
    chk_data("t5_empty_rd", 32'd0);
    chk_status("t5_empty_lvl", 32'h0000_0000);
    pulse_trig();
    photons(2);
    wr_ctrl(32'h2);
    chk_status("t5_flush_mid", 32'h0000_0000);
    pulse_trig();
    chk_status("t5_rearm", 32'h4000_0000);
    check("t5_irq", {31'd0, irq}, 32'd0);

    // 6a: saturation on the narrow-counter instance (max 15)
    pulse_trig2();
    photons2(20);
    pulse_trig2();
    rd2(1'b1, d);
    check("t6_sat_status", d, 32'h4000_0001);
    rd2(1'b0, d);
    check("t6_sat_data", d, 32'h0000_000F);

    // 6b: reset in the middle of a window
    photons(3);
    pulse_trig();
    photons(2);
    check("t6_pre_irq", {31'd0, irq}, 32'd1);
    chk_status("t6_pre_status", 32'h4000_0001);
    RST = 1'b1;
    tick();
    check("t6_rst_readdata", readdata, 32'd0);
    check("t6_rst_irq", {31'd0, irq}, 32'd0);
    RST = 1'b0;
    chk_status("t6_rst_status", 32'h0000_0000);
    pulse_trig();
    photons(1);
    pulse_trig();
    chk_data("t6_fresh_window", 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
